wb_cmd_master: RTL
==================

// Module: wb_cmd_master
// PURPOSE
//  Wishbone classic master that sits directly upstream of the SPI bridge top (ADR_I/DAT_I/WE_I/CYC_I/STB_I/ACK_O).
//  Accepts register read/write commands on a valid/ready stream and buffers them in a small FIFO.
//  Replays each command as one single classic bus cycle, with an ACK timeout.
//  Returns one response per command (read data or error) on a second valid/ready stream.
// PARAMETERS
//  FIFO_DEPTH  4     command FIFO entries; power of two, >=2
//  TIMEOUT     1023  max cycles STB_O may wait for ACK_I before abort; >=2
//  ADR_W       8     bus address width
//  DAT_W       32    bus data width
// PORTS
//  CLK_I      in   1      clock, all logic on rising edge
//  RST_I      in   1      synchronous, active-high reset
//  CMD_VALID  in   1      command offered
//  CMD_READY  out  1      command accepted when VALID&READY at clock edge
//  CMD_WE     in   1      1=write, 0=read
//  CMD_ADR    in   ADR_W  register address
//  CMD_DAT    in   DAT_W  write data (ignored for reads)
//  RSP_VALID  out  1      response available
//  RSP_READY  in   1      response consumed when VALID&READY at clock edge
//  RSP_DAT    out  DAT_W  read data; 0 for writes and errors
//  RSP_ERR    out  1      1=timeout abort
//  ADR_O      out  ADR_W  to bridge ADR_I
//  DAT_O      out  DAT_W  to bridge DAT_I
//  DAT_I      in   DAT_W  from bridge DAT_O
//  WE_O       out  1      to bridge WE_I
//  CYC_O      out  1      to bridge CYC_I
//  STB_O      out  1      to bridge STB_I
//  ACK_I      in   1      from bridge ACK_O
// BEHAVIOUR
//  Reset
//   All outputs 0 except CMD_READY=1 from the first cycle after reset.
//   FIFO empty, FSM in IDLE, timeout counter 0.
//   RST_I mid-cycle drops CYC_O/STB_O at that edge, discards FIFO contents and any pending response.
//  FIFO
//   CMD_READY = (count != FIFO_DEPTH), a function of the registered count only.
//   Push while full is refused. Push and pop in the same cycle keep count unchanged.
//   Pointers wrap modulo FIFO_DEPTH.
//  FSM: IDLE -> BUS -> RSP -> GAP -> IDLE
//   IDLE: when the FIFO is non-empty, pop the head. Next edge: drive ADR_O/DAT_O/WE_O, set CYC_O=STB_O=1, clear counter, go BUS.
//    Latency: command accepted at edge N on an empty FIFO -> CYC_O high after edge N+2.
//   BUS: hold all master outputs stable.
//    If ACK_I=1: capture DAT_I (reads) or 0 (writes) into RSP_DAT, RSP_ERR=0, CYC_O=STB_O=WE_O=0, RSP_VALID=1, go RSP.
//    Else if counter==TIMEOUT-1: drop CYC/STB, RSP_DAT=0, RSP_ERR=1, RSP_VALID=1, go RSP.
//    Else counter++. ACK on the final counted cycle wins over timeout.
//   RSP: hold RSP_* stable until RSP_READY. On the handshake edge, RSP_VALID=0 and go GAP.
//   GAP: stay until ACK_I=0 for one sampled cycle (the bridge holds ACK while STB is seen).
//    Guarantees CYC_O low for >=1 cycle between bus cycles. Then go IDLE.
//  ACK_I outside BUS is ignored. DAT_O/ADR_O keep their last values when CYC_O=0.
//  Commands are executed strictly in order; exactly one response per accepted command.
// STRUCTURE
//  Shared package wb_cmd_pkg:
//   - FSM state encoding (IDLE/BUS/RSP/GAP)
//   - command record layout {we, adr, dat}
//   - bridge register address constants (REG_CTRL=8'h01, REG_CFG=8'h02)
//  One sub-module: wb_cmd_fifo (sync FIFO: push/pop/count, full/empty).
//  Top file holds the FSM, timeout counter and response registers.
// TESTING
//  Bench pairs this block with the SPI bridge top and the M25AA010A model, CLK_I period 2 units.
//  1 Write 1/read 1: push {WE=1,ADR=8'h01,DAT=32'h4154_A000} then {WE=0,ADR=8'h01}
//    -> two bus cycles in order; responses {DAT=0,ERR=0} then {DAT=32'h4154_A000,ERR=0}.
//  2 FIFO full: hold RSP_READY=0, push 6 commands -> CMD_READY=0 after 4 + 1 in flight;
//    release RSP_READY -> 5 responses in order, remaining command accepted.
//  3 Timeout: ACK_I forced 0, TIMEOUT=16 -> STB_O high exactly 16 cycles, then RSP_ERR=1, RSP_DAT=0, next command proceeds.
//  4 ACK on the last permitted cycle (16th) -> RSP_ERR=0, read data captured.
//  5 Back-pressure: RSP_READY low 10 cycles -> RSP_* stable, CYC_O stays 0 throughout, no new bus cycle.
//  6 RST_I during BUS -> CYC_O/STB_O=0 next edge, RSP_VALID=0, CMD_READY=1, FIFO empty; a fresh command then completes normally.

Source files
------------

// File: rtl/wb_cmd_pkg.sv
// Shared types and constants for the Wishbone command master:
// FSM state encoding, command record layout and bridge register addresses.
package wb_cmd_pkg;

    localparam int CMD_ADR_W = 8;
    localparam int CMD_DAT_W = 32;

    localparam logic [CMD_ADR_W-1:0] REG_CTRL = 8'h01;
    localparam logic [CMD_ADR_W-1:0] REG_CFG  = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RSP  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    typedef struct packed {
        logic                 we;
        logic [CMD_ADR_W-1:0] adr;
        logic [CMD_DAT_W-1:0] dat;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO: single clock, power-of-two depth, head visible
// combinationally; full/empty derive from the registered count only.
module wb_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 41
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full    = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    // NOTE: non-blocking assignments in clocked blocks, so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; an entry is only read after it was written.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic master: buffers register commands, replays each as one
// bus cycle with an ACK timeout, and returns one response per command.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023,
    parameter int ADR_W      = CMD_ADR_W,
    parameter int DAT_W      = CMD_DAT_W
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic             CMD_WE,
    input  logic [ADR_W-1:0] CMD_ADR,
    input  logic [DAT_W-1:0] CMD_DAT,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [DAT_W-1:0] RSP_DAT,
    output logic             RSP_ERR,
    output logic [ADR_W-1:0] ADR_O,
    output logic [DAT_W-1:0] DAT_O,
    input  logic [DAT_W-1:0] DAT_I,
    output logic             WE_O,
    output logic             CYC_O,
    output logic             STB_O,
    input  logic             ACK_I
);

    localparam int              REC_W    = 1 + ADR_W + DAT_W;
    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             r_state;
    logic               r_load;
    logic [REC_W-1:0]   r_cmd;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADR_W-1:0]   r_adr;
    logic [DAT_W-1:0]   r_dat;
    logic               r_we;
    logic               r_cyc;
    logic               r_rsp_valid;
    logic [DAT_W-1:0]   r_rsp_dat;
    logic               r_rsp_err;

    state_t             w_state_nxt;
    logic               w_load_nxt;
    logic [REC_W-1:0]   w_cmd_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [ADR_W-1:0]   w_adr_nxt;
    logic [DAT_W-1:0]   w_dat_nxt;
    logic               w_we_nxt;
    logic               w_cyc_nxt;
    logic               w_rsp_valid_nxt;
    logic [DAT_W-1:0]   w_rsp_dat_nxt;
    logic               w_rsp_err_nxt;

    logic               w_push;
    logic               w_pop;
    logic [REC_W-1:0]   w_head;
    logic               w_full;
    logic               w_empty;

    assign CMD_READY = !w_full;
    assign w_push    = CMD_VALID && CMD_READY;

    wb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .i_clk   (CLK_I),
        .i_rst   (RST_I),
        .i_push  (w_push),
        .i_data  ({CMD_WE, CMD_ADR, CMD_DAT}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // NOTE: every next-value is defaulted first, so no path through the case can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_load_nxt      = r_load;
        w_cmd_nxt       = r_cmd;
        w_cnt_nxt       = r_cnt;
        w_adr_nxt       = r_adr;
        w_dat_nxt       = r_dat;
        w_we_nxt        = r_we;
        w_cyc_nxt       = r_cyc;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_dat_nxt   = r_rsp_dat;
        w_rsp_err_nxt   = r_rsp_err;
        w_pop           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Pop into a holding register first, drive the bus one edge later.
                if (r_load) begin
                    w_we_nxt    = r_cmd[REC_W-1];
                    w_adr_nxt   = r_cmd[ADR_W+DAT_W-1:DAT_W];
                    w_dat_nxt   = r_cmd[DAT_W-1:0];
                    w_cyc_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_load_nxt  = 1'b0;
                    w_state_nxt = ST_BUS;
                end else if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_cmd_nxt  = w_head;
                    w_load_nxt = 1'b1;
                end
            end
            ST_BUS: begin
                if (ACK_I) begin
                    w_rsp_dat_nxt   = r_we ? '0 : DAT_I;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_cyc_nxt       = 1'b0;
                    w_we_nxt        = 1'b0;
                    w_state_nxt     = ST_RSP;
                end else if (r_cnt == CNT_LAST) begin
                    w_rsp_dat_nxt   = '0;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_valid_nxt = 1'b1;
                    w_cyc_nxt       = 1'b0;
                    w_state_nxt     = ST_RSP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_RSP: begin
                if (RSP_READY) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = ST_GAP;
                end
            end
            ST_GAP: begin
                // The bridge may still hold ACK from the previous strobe.
                if (!ACK_I) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state     <= ST_IDLE;
            r_load      <= 1'b0;
            r_cmd       <= '0;
            r_cnt       <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_we        <= 1'b0;
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_load      <= w_load_nxt;
            r_cmd       <= w_cmd_nxt;
            r_cnt       <= w_cnt_nxt;
            r_adr       <= w_adr_nxt;
            r_dat       <= w_dat_nxt;
            r_we        <= w_we_nxt;
            r_cyc       <= w_cyc_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_dat   <= w_rsp_dat_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    assign ADR_O     = r_adr;
    assign DAT_O     = r_dat;
    assign WE_O      = r_we;
    assign CYC_O     = r_cyc;
    assign STB_O     = r_cyc;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_DAT   = r_rsp_dat;
    assign RSP_ERR   = r_rsp_err;

endmodule
